// File: rtl/edge_counter_pkg.sv
// Shared types, constants and helpers for the multi-channel edge counter.
package edge_counter_pkg;

  // Widest counter any channel may be built with; shadow storage uses this width.
  localparam int MAX_WIDTH = 32;

  // Counter behaviour on increment from all-ones.
  localparam int MODE_WRAP     = 0;
  localparam int MODE_SATURATE = 1;

  // One channel's pair of counts, stored at the package-level maximum width.
  typedef struct packed {
    logic [MAX_WIDTH-1:0] pos;
    logic [MAX_WIDTH-1:0] neg;
  } ch_counts_t;

  // All-ones value of a counter that is `width` bits wide.
  function automatic logic [MAX_WIDTH-1:0] CNT_MAX(input int width);
    return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
  endfunction

  // Width of the channel-select bus, never narrower than one bit.
  function automatic int sel_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/edge_counter_channel.sv
// One input channel: synchroniser, priming, edge detect and the two edge counters.
module edge_counter_channel
  import edge_counter_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int SATURATE    = MODE_SATURATE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_signal,
  input  logic             i_enable,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_pos,
  output logic [WIDTH-1:0] o_neg,
  output logic             o_overflow
);

  localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(CNT_MAX(WIDTH));
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] WRAP_VAL = (SATURATE == MODE_SATURATE) ? ALL_ONES : '0;

  logic [SYNC_STAGES-1:0] r_sync;
  // r_fill marks which synchroniser stages hold a genuine post-reset sample,
  // so the reset value of the chain is never mistaken for input data.
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_primed;
  logic                   r_prev;
  logic [WIDTH-1:0]       r_pos;
  logic [WIDTH-1:0]       r_neg;
  logic                   r_overflow;

  logic w_sync_out;
  logic w_sample_ok;
  logic w_rise;
  logic w_fall;
  logic w_pos_inc;
  logic w_neg_inc;
  logic w_pos_ovf;
  logic w_neg_ovf;

  assign w_sync_out  = r_sync[SYNC_STAGES-1];
  assign w_sample_ok = r_fill[SYNC_STAGES-1];
  assign w_rise      = r_primed & w_sync_out & ~r_prev;
  assign w_fall      = r_primed & ~w_sync_out & r_prev;
  assign w_pos_inc   = i_enable & w_rise;
  assign w_neg_inc   = i_enable & w_fall;
  assign w_pos_ovf   = w_pos_inc & (r_pos == ALL_ONES);
  assign w_neg_ovf   = w_neg_inc & (r_neg == ALL_ONES);

  // Synchroniser chain and its sample-valid tracker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_fill <= '0;
    end else begin
      r_sync[0] <= i_signal;
      r_fill[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
        r_fill[i] <= r_fill[i-1];
      end
    end
  end

  // Previous-sample flop; tracks the input regardless of enable, primes on first real sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_primed <= 1'b0;
      r_prev   <= 1'b0;
    end else if (w_sample_ok) begin
      r_primed <= 1'b1;
      r_prev   <= w_sync_out;
    end
  end

  // Edge counters and sticky overflow; clear beats any same-cycle edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pos      <= '0;
      r_neg      <= '0;
      r_overflow <= 1'b0;
    end else if (i_clear) begin
      r_pos      <= '0;
      r_neg      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pos_inc) begin
        r_pos <= w_pos_ovf ? WRAP_VAL : (r_pos + ONE);
      end
      if (w_neg_inc) begin
        r_neg <= w_neg_ovf ? WRAP_VAL : (r_neg + ONE);
      end
      r_overflow <= r_overflow | w_pos_ovf | w_neg_ovf;
    end
  end

  assign o_pos      = r_pos;
  assign o_neg      = r_neg;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/multi_edge_counter.sv
// Multi-channel edge counter with atomic snapshot into shadow registers and a read mux.
module multi_edge_counter
  import edge_counter_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int SATURATE    = MODE_SATURATE
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            signal,
  input  logic                           enable,
  input  logic [CHANNELS-1:0]            clear,
  input  logic                           snapshot,
  input  logic [sel_width(CHANNELS)-1:0] rd_sel,
  output logic [WIDTH-1:0]               rd_posedge,
  output logic [WIDTH-1:0]               rd_negedge,
  output logic [CHANNELS-1:0]            overflow,
  output logic                           snap_valid
);

  logic [WIDTH-1:0] w_pos [CHANNELS];
  logic [WIDTH-1:0] w_neg [CHANNELS];
  ch_counts_t       r_shadow [CHANNELS];
  logic             r_snap_valid;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    edge_counter_channel #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .SATURATE    (SATURATE)
    ) u_channel (
      .clk        (clk),
      .reset      (reset),
      .i_signal   (signal[gi]),
      .i_enable   (enable),
      .i_clear    (clear[gi]),
      .o_pos      (w_pos[gi]),
      .o_neg      (w_neg[gi]),
      .o_overflow (overflow[gi])
    );
  end

  // Shadow capture: all channels load their pre-update live counts on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_shadow[i] <= '0;
      end
      r_snap_valid <= 1'b0;
    end else if (snapshot) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_shadow[i].pos <= MAX_WIDTH'(w_pos[i]);
        r_shadow[i].neg <= MAX_WIDTH'(w_neg[i]);
      end
      r_snap_valid <= 1'b1;
    end
  end

  // Read mux over the shadow array; unused select codes read as zero.
  always_comb begin
    rd_posedge = '0;
    rd_negedge = '0;
    if (int'(rd_sel) < CHANNELS) begin
      rd_posedge = r_shadow[rd_sel].pos[WIDTH-1:0];
      rd_negedge = r_shadow[rd_sel].neg[WIDTH-1:0];
    end else begin
      rd_posedge = '0;
      rd_negedge = '0;
    end
  end

  assign snap_valid = r_snap_valid;

endmodule

// File: tb/tb_multi_edge_counter.sv
// Scoreboard bench: saturating and wrapping instances driven in parallel against an event-level model.
module tb_multi_edge_counter;

  localparam int CH   = 3;
  localparam int W    = 4;
  localparam int S    = 2;
  localparam int SELW = 2;
  localparam int MAXV = (1 << W) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [CH-1:0]   sig = '0;
  logic            enable = 1'b0;
  logic [CH-1:0]   clr = '0;
  logic            snap = 1'b0;
  logic [SELW-1:0] rd_sel = '0;
  logic            rd_req = 1'b0;

  logic [W-1:0]  s_pos, s_neg, w_pos, w_neg;
  logic [CH-1:0] s_ov, w_ov;
  logic          s_sv, w_sv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_edge_counter #(.CHANNELS(CH), .WIDTH(W), .SYNC_STAGES(S), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .signal(sig), .enable(enable), .clear(clr),
    .snapshot(snap), .rd_sel(rd_sel), .rd_posedge(s_pos), .rd_negedge(s_neg),
    .overflow(s_ov), .snap_valid(s_sv)
  );

  multi_edge_counter #(.CHANNELS(CH), .WIDTH(W), .SYNC_STAGES(S), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .signal(sig), .enable(enable), .clear(clr),
    .snapshot(snap), .rd_sel(rd_sel), .rd_posedge(w_pos), .rd_negedge(w_neg),
    .overflow(w_ov), .snap_valid(w_sv)
  );

  // Reference model: live counts, shadows and the input history since reset release.
  int            m_ps [CH], m_ns [CH], m_pw [CH], m_nw [CH];
  int            sh_ps [CH], sh_ns [CH], sh_pw [CH], sh_nw [CH];
  logic [CH-1:0] m_ov;
  bit            m_sv;
  logic [CH-1:0] hist [$];
  int            k;

  typedef struct {
    int            sel;
    int            ps, ns, pw, nw;
    logic [CH-1:0] ov;
    bit            sv;
  } exp_t;
  exp_t q [$];

  function automatic int bump(input int c, input bit sat);
    if (c == MAXV) return sat ? MAXV : 0;
    return c + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_ps[i] = 0; m_ns[i] = 0; m_pw[i] = 0; m_nw[i] = 0;
      sh_ps[i] = 0; sh_ns[i] = 0; sh_pw[i] = 0; sh_nw[i] = 0;
    end
    m_ov = '0;
    m_sv = 1'b0;
    hist.delete();
    hist.push_back('0);
    k = 0;
  endtask

  // Drive one cycle of inputs, record expectations, then advance the model by one edge.
  // An input change between samples k-S-1 and k-S is seen at edge k; the first
  // comparable pair is samples 1 and 2 after reset release.
  task automatic step(input logic [CH-1:0] s, input logic en, input logic [CH-1:0] c,
                      input logic sn, input logic rd, input int sel);
    exp_t          e;
    logic [CH-1:0] a, b;
    sig = s; enable = en; clr = c; snap = sn; rd_req = rd; rd_sel = sel[SELW-1:0];
    if (rd) begin
      e.sel = sel;
      if (sel < CH) begin
        e.ps = sh_ps[sel]; e.ns = sh_ns[sel]; e.pw = sh_pw[sel]; e.nw = sh_nw[sel];
      end else begin
        e.ps = 0; e.ns = 0; e.pw = 0; e.nw = 0;
      end
      e.ov = m_ov;
      e.sv = m_sv;
      q.push_back(e);
    end
    if (sn) begin
      sh_ps = m_ps; sh_ns = m_ns; sh_pw = m_pw; sh_nw = m_nw;
      m_sv = 1'b1;
    end
    k++;
    hist.push_back(s);
    a = '0; b = '0;
    if (k >= S + 2) begin
      a = hist[k-S-1];
      b = hist[k-S];
    end
    for (int i = 0; i < CH; i++) begin
      if (c[i]) begin
        m_ps[i] = 0; m_ns[i] = 0; m_pw[i] = 0; m_nw[i] = 0; m_ov[i] = 1'b0;
      end else if (en && k >= S + 2) begin
        if (b[i] && !a[i]) begin
          if (m_ps[i] == MAXV) m_ov[i] = 1'b1;
          m_ps[i] = bump(m_ps[i], 1'b1);
          m_pw[i] = bump(m_pw[i], 1'b0);
        end
        if (!b[i] && a[i]) begin
          if (m_ns[i] == MAXV) m_ov[i] = 1'b1;
          m_ns[i] = bump(m_ns[i], 1'b1);
          m_nw[i] = bump(m_nw[i], 1'b0);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [CH-1:0] s);
    reset = 1'b1;
    sig = s; enable = 1'b1; clr = '0; snap = 1'b0; rd_req = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check(input string name, input int sel, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s sel=%0d got=%0d want=%0d", name, sel, act, exp);
    end
  endtask

  // Monitor: whenever a readout is presented, pop the oldest expectation and compare.
  always @(negedge clk) begin
    exp_t e;
    if (rd_req) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty sel=%0d got=read want=queued", int'(rd_sel));
      end else begin
        e = q.pop_front();
        check("rd_sel_echo", e.sel, int'(rd_sel), e.sel);
        check("sat_pos", e.sel, int'(s_pos), e.ps);
        check("sat_neg", e.sel, int'(s_neg), e.ns);
        check("wrap_pos", e.sel, int'(w_pos), e.pw);
        check("wrap_neg", e.sel, int'(w_neg), e.nw);
        check("sat_overflow", e.sel, int'(s_ov), int'(e.ov));
        check("wrap_overflow", e.sel, int'(w_ov), int'(e.ov));
        check("sat_snap_valid", e.sel, int'(s_sv), int'(e.sv));
        check("wrap_snap_valid", e.sel, int'(w_sv), int'(e.sv));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CH-1:0] rs, rc;
    void'($urandom(32'd1234));

    // Reset state and priming with channel 0 held high through reset release.
    do_reset(3'b001);
    for (int c = 0; c < 4; c++) step(3'b001, 1'b1, 3'b000, 1'b0, 1'b1, c);
    repeat (10) step(3'b001, 1'b1, 3'b000, 1'b0, 1'b0, 0);
    step(3'b001, 1'b1, 3'b000, 1'b1, 1'b0, 0);
    for (int j = 0; j < 6; j++) step(3'b000, 1'b1, 3'b000, 1'b1, 1'b1, 0);
    step(3'b000, 1'b1, 3'b000, 1'b0, 1'b1, 0);

    // Seventeen rising edges on channel 2: saturate vs wrap, then clear.
    for (int r = 0; r < 17; r++) begin
      step(3'b100, 1'b1, 3'b000, 1'b0, 1'b0, 0);
      step(3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 0);
    end
    repeat (S + 2) step(3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 0);
    step(3'b000, 1'b1, 3'b000, 1'b1, 1'b0, 0);
    step(3'b000, 1'b1, 3'b000, 1'b0, 1'b1, 2);
    step(3'b000, 1'b1, 3'b100, 1'b0, 1'b1, 2);
    step(3'b000, 1'b1, 3'b000, 1'b1, 1'b1, 2);
    step(3'b000, 1'b1, 3'b000, 1'b0, 1'b1, 2);

    // Channel 1: five edges, then clear and snapshot on the edge that would make six.
    for (int r = 0; r < 5; r++) begin
      step(3'b010, 1'b1, 3'b000, 1'b0, 1'b0, 0);
      step(3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 0);
    end
    repeat (S + 2) step(3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 0);
    step(3'b010, 1'b1, 3'b000, 1'b0, 1'b0, 0);
    repeat (S - 1) step(3'b010, 1'b1, 3'b000, 1'b0, 1'b0, 0);
    step(3'b010, 1'b1, 3'b010, 1'b1, 1'b0, 0);
    step(3'b010, 1'b1, 3'b000, 1'b1, 1'b1, 1);
    step(3'b010, 1'b1, 3'b000, 1'b0, 1'b1, 1);

    // Enable gating on channel 2: three toggles while disabled, static re-enable, one toggle.
    step(3'b010, 1'b0, 3'b000, 1'b0, 1'b0, 0);
    step(3'b110, 1'b0, 3'b000, 1'b0, 1'b0, 0);
    step(3'b110, 1'b0, 3'b000, 1'b0, 1'b0, 0);
    step(3'b010, 1'b0, 3'b000, 1'b0, 1'b0, 0);
    step(3'b010, 1'b0, 3'b000, 1'b0, 1'b0, 0);
    step(3'b110, 1'b0, 3'b000, 1'b0, 1'b0, 0);
    repeat (S + 2) step(3'b110, 1'b0, 3'b000, 1'b0, 1'b0, 0);
    repeat (5) step(3'b110, 1'b1, 3'b000, 1'b0, 1'b0, 0);
    step(3'b110, 1'b1, 3'b000, 1'b1, 1'b0, 0);
    step(3'b110, 1'b1, 3'b000, 1'b0, 1'b1, 2);
    step(3'b010, 1'b1, 3'b000, 1'b0, 1'b0, 0);
    repeat (S + 2) step(3'b010, 1'b1, 3'b000, 1'b0, 1'b0, 0);
    step(3'b010, 1'b1, 3'b000, 1'b1, 1'b0, 0);
    step(3'b010, 1'b1, 3'b000, 1'b0, 1'b1, 2);

    // Random toggling, enable and clears with periodic snapshots and rolling readout.
    rs = 3'b010;
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 9) == 0) rs[i] = ~rs[i];
        rc[i] = ($urandom_range(0, 149) == 0);
      end
      step(rs, ($urandom_range(0, 9) != 0), rc, (n % 16 == 0), 1'b1, n % 4);
    end

    // Reset mid-operation with channels 0 and 1 high, then re-prime and count a fall.
    do_reset(3'b011);
    for (int c = 0; c < 4; c++) step(3'b011, 1'b1, 3'b000, 1'b0, 1'b1, c);
    repeat (6) step(3'b011, 1'b1, 3'b000, 1'b0, 1'b0, 0);
    step(3'b011, 1'b1, 3'b000, 1'b1, 1'b0, 0);
    step(3'b011, 1'b1, 3'b000, 1'b0, 1'b1, 0);
    step(3'b011, 1'b1, 3'b000, 1'b0, 1'b1, 1);
    repeat (S + 3) step(3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 0);
    step(3'b000, 1'b1, 3'b000, 1'b1, 1'b0, 0);
    step(3'b000, 1'b1, 3'b000, 1'b0, 1'b1, 0);
    step(3'b000, 1'b1, 3'b000, 1'b0, 1'b1, 1);
    step(3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 0);

    check("queue_drained", 0, q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
